// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receiver.
//   uart_rx_state_t  : receiver FSM state encoding
//   UART_MIN_BITS    : data bits encoded by cfg_bits_i == 0
//   UART_SYNC_STAGES : flops in the rx_i synchroniser
package uart_pkg;

    localparam int unsigned UART_MIN_BITS    = 5;
    localparam int unsigned UART_SYNC_STAGES = 2;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: input conditioning for the UART receiver.
//   Synchronises rx_i (s1, s2), adds a third flop (s3) for falling-edge
//   detection and, when UART_RX_MAJORITY_EN is defined, a 2-of-3 majority
//   filter over the last three s2 values.
// Ports:
//   clk_i  in  : system clock
//   rst_i  in  : synchronous active-high reset (all flops reset to 1)
//   rx_i   in  : asynchronous serial line, idle high
//   line_o out : conditioned line level used for bit sampling
//   fall_o out : high while s3=1 and s2=0 (falling edge seen)
// Build option: UART_RX_MAJORITY_EN
module uart_rx_sampler
    import uart_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic rx_i,
    output logic line_o,
    output logic fall_o
);

    logic [UART_SYNC_STAGES-1:0] r_sync;
    logic                        r_s3;
    logic                        w_s2;

    assign w_s2   = r_sync[UART_SYNC_STAGES-1];
    assign fall_o = r_s3 & ~w_s2;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sync <= '1;
            r_s3   <= 1'b1;
        end else begin
            r_sync <= {r_sync[UART_SYNC_STAGES-2:0], rx_i};
            r_s3   <= w_s2;
        end
    end

`ifdef UART_RX_MAJORITY_EN
    // s3 already holds s2 from one cycle back; r_s4 holds it from two back,
    // so the vote covers s2 at compare-2, compare-1 and compare.
    logic r_s4;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s4 <= 1'b1;
        end else begin
            r_s4 <= r_s3;
        end
    end

    assign line_o = (r_s4 & r_s3) | (r_s4 & w_s2) | (r_s3 & w_s2);
`else
    assign line_o = w_s2;
`endif

endmodule

// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver (5-8 data bits LSB-first, optional
// even parity, one stop bit checked) with a valid/ready byte output.
// Ports:
//   clk_i           in  : system clock
//   rst_i           in  : synchronous active-high reset
//   rx_i            in  : serial line, asynchronous, idle high
//   busy_o          out : FSM not in IDLE
//   cfg_en_i        in  : receiver enable
//   cfg_div_i[15:0] in  : bit period = cfg_div_i+1 cycles (min 4)
//   cfg_parity_en_i in  : even-parity bit follows data
//   cfg_bits_i[1:0] in  : data bits = cfg_bits_i+5
//   rx_data_o[7:0]  out : received byte, zero-extended
//   rx_valid_o      out : byte available
//   rx_ready_i      in  : consumer accepts byte
//   err_parity_o    out : one-cycle pulse, parity mismatch
//   err_frame_o     out : one-cycle pulse, stop bit sampled 0
//   err_overrun_o   out : one-cycle pulse, completed frame dropped
// Build option: UART_RX_MAJORITY_EN (forwarded to uart_rx_sampler)
module uart_rx
    import uart_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_i,
    output logic        busy_o,
    input  logic        cfg_en_i,
    input  logic [15:0] cfg_div_i,
    input  logic        cfg_parity_en_i,
    input  logic [1:0]  cfg_bits_i,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    input  logic        rx_ready_i,
    output logic        err_parity_o,
    output logic        err_frame_o,
    output logic        err_overrun_o
);

    localparam logic [2:0] LAST_OFS = 3'(UART_MIN_BITS - 1);

    uart_rx_state_t r_state, w_next_state;

    logic [15:0] r_cnt;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_par_acc;
    logic        r_par_bad;
    logic [7:0]  r_data;
    logic        r_valid;
    logic        r_err_parity, r_err_frame, r_err_overrun;

    logic        w_line, w_fall;
    logic [15:0] w_cmp;
    logic        w_hit, w_last_bit, w_stop;
    logic        w_err_frame, w_err_parity, w_err_overrun, w_load;

    uart_rx_sampler u_sampler (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .rx_i   (rx_i),
        .line_o (w_line),
        .fall_o (w_fall)
    );

    assign busy_o        = (r_state != RX_IDLE);
    assign rx_data_o     = r_data;
    assign rx_valid_o    = r_valid;
    assign err_parity_o  = r_err_parity;
    assign err_frame_o   = r_err_frame;
    assign err_overrun_o = r_err_overrun;

    always_comb begin
        w_next_state = r_state;
        w_cmp        = (r_state == RX_START) ? {1'b0, cfg_div_i[15:1]} : cfg_div_i;
        // >= rather than == so a mid-frame divider change cannot strand the counter
        w_hit        = (r_cnt >= w_cmp);
        w_last_bit   = (r_bit_cnt == ({1'b0, cfg_bits_i} + LAST_OFS));

        case (r_state)
            RX_IDLE:   if (w_fall) w_next_state = RX_START;
            RX_START:  if (w_hit) w_next_state = w_line ? RX_IDLE : RX_DATA;
            RX_DATA:   if (w_hit && w_last_bit)
                           w_next_state = cfg_parity_en_i ? RX_PARITY : RX_STOP;
            RX_PARITY: if (w_hit) w_next_state = RX_STOP;
            RX_STOP:   if (w_hit) w_next_state = RX_IDLE;
            default:   w_next_state = RX_IDLE;
        endcase

        if (!cfg_en_i) w_next_state = RX_IDLE;

        w_stop        = cfg_en_i && (r_state == RX_STOP) && w_hit;
        w_err_frame   = w_stop && !w_line;
        w_err_parity  = w_stop && w_line && r_par_bad;
        w_err_overrun = w_stop && w_line && !r_par_bad && r_valid && !rx_ready_i;
        w_load        = w_stop && w_line && !r_par_bad && (!r_valid || rx_ready_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt         <= '0;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_par_acc     <= 1'b0;
            r_par_bad     <= 1'b0;
            r_data        <= '0;
            r_valid       <= 1'b0;
            r_err_parity  <= 1'b0;
            r_err_frame   <= 1'b0;
            r_err_overrun <= 1'b0;
        end else begin
            r_err_parity  <= w_err_parity;
            r_err_frame   <= w_err_frame;
            r_err_overrun <= w_err_overrun;

            if (!cfg_en_i || r_state == RX_IDLE || w_hit) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 16'd1;
            end

            if (!cfg_en_i || r_state == RX_IDLE) begin
                r_bit_cnt <= '0;
            end else if (r_state == RX_DATA && w_hit) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end

            // Clearing at frame start keeps bits above the configured width zero.
            if (cfg_en_i && r_state == RX_IDLE && w_fall) begin
                r_shift   <= '0;
                r_par_acc <= 1'b0;
                r_par_bad <= 1'b0;
            end else if (cfg_en_i && r_state == RX_DATA && w_hit) begin
                r_shift[r_bit_cnt] <= w_line;
                r_par_acc          <= r_par_acc ^ w_line;
            end else if (cfg_en_i && r_state == RX_PARITY && w_hit) begin
                r_par_bad <= w_line ^ r_par_acc;
            end

            if (w_load) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && rx_ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx.
// Build option: UART_RX_MAJORITY_EN enables the glitch-rejection case.
module tb_uart_rx;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        rx_i;
    logic        busy_o;
    logic        cfg_en_i;
    logic [15:0] cfg_div_i;
    logic        cfg_parity_en_i;
    logic [1:0]  cfg_bits_i;
    logic [7:0]  rx_data_o;
    logic        rx_valid_o;
    logic        rx_ready_i;
    logic        err_parity_o;
    logic        err_frame_o;
    logic        err_overrun_o;

    int n_checks = 0;
    int n_fail   = 0;
    int n_perr   = 0;
    int n_ferr   = 0;
    int n_ovr    = 0;

    always #5 clk = ~clk;

    uart_rx dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .rx_i            (rx_i),
        .busy_o          (busy_o),
        .cfg_en_i        (cfg_en_i),
        .cfg_div_i       (cfg_div_i),
        .cfg_parity_en_i (cfg_parity_en_i),
        .cfg_bits_i      (cfg_bits_i),
        .rx_data_o       (rx_data_o),
        .rx_valid_o      (rx_valid_o),
        .rx_ready_i      (rx_ready_i),
        .err_parity_o    (err_parity_o),
        .err_frame_o     (err_frame_o),
        .err_overrun_o   (err_overrun_o)
    );

    // Counting high cycles means a stretched pulse shows up as an extra count.
    always @(negedge clk) begin
        if (err_parity_o)  n_perr++;
        if (err_frame_o)   n_ferr++;
        if (err_overrun_o) n_ovr++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives start, data (LSB first), optional parity, stop. Stops early after
    // abort_after bit periods; glitch_idx inverts one mid-bit cycle of that bit.
    task automatic send_frame(input logic [7:0] data, input int nbits, input bit par_en,
                              input bit par_flip, input bit stop_val,
                              input int abort_after, input int glitch_idx);
        logic [10:0] fr;
        int          len;
        bit          p;
        p     = par_flip;
        fr    = '1;
        fr[0] = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            fr[1+i] = data[i];
            p       = p ^ data[i];
        end
        len = 1 + nbits;
        if (par_en) begin
            fr[len] = p;
            len++;
        end
        fr[len] = stop_val;
        len++;
        for (int b = 0; b < len; b++) begin
            if (b == abort_after) break;
            for (int c = 0; c <= int'(cfg_div_i); c++) begin
                rx_i = (b == glitch_idx && c == (int'(cfg_div_i) + 1) / 2) ? ~fr[b] : fr[b];
                @(posedge clk);
                #1;
            end
        end
        rx_i = 1'b1;
    endtask

    task automatic accept_byte(input string tag);
        rx_ready_i = 1'b1;
        wait_clks(1);
        rx_ready_i = 1'b0;
        check_eq(tag, {31'd0, rx_valid_o}, 32'd0);
    endtask

    initial begin
        rst_i           = 1'b1;
        rx_i            = 1'b1;
        cfg_en_i        = 1'b0;
        cfg_div_i       = 16'd15;
        cfg_parity_en_i = 1'b0;
        cfg_bits_i      = 2'd3;
        rx_ready_i      = 1'b0;
        wait_clks(3);

        check_eq("rst_data",  {24'd0, rx_data_o}, 32'h00);
        check_eq("rst_valid", {31'd0, rx_valid_o}, 32'd0);
        check_eq("rst_busy",  {31'd0, busy_o}, 32'd0);
        check_eq("rst_errs",  {29'd0, err_parity_o, err_frame_o, err_overrun_o}, 32'd0);

        rst_i    = 1'b0;
        cfg_en_i = 1'b1;
        wait_clks(20);

        // Basic 8N1 frame and handshake
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, -1, -1);
        check_eq("basic_data",  {24'd0, rx_data_o}, 32'hA5);
        check_eq("basic_valid", {31'd0, rx_valid_o}, 32'd1);
        check_eq("basic_busy",  {31'd0, busy_o}, 32'd0);
        wait_clks(5);
        check_eq("basic_hold_valid", {31'd0, rx_valid_o}, 32'd1);
        check_eq("basic_hold_data",  {24'd0, rx_data_o}, 32'hA5);
        accept_byte("basic_accept");

        // 7E1: correct parity then flipped parity
        cfg_bits_i      = 2'd2;
        cfg_parity_en_i = 1'b1;
        send_frame(8'h35, 7, 1'b1, 1'b0, 1'b1, -1, -1);
        check_eq("par_ok_data",  {24'd0, rx_data_o}, 32'h35);
        check_eq("par_ok_valid", {31'd0, rx_valid_o}, 32'd1);
        check_eq("par_ok_nerr",  n_perr, 32'd0);
        accept_byte("par_ok_accept");
        send_frame(8'h35, 7, 1'b1, 1'b1, 1'b1, -1, -1);
        wait_clks(2);
        check_eq("par_bad_nerr",  n_perr, 32'd1);
        check_eq("par_bad_valid", {31'd0, rx_valid_o}, 32'd0);

        // Frame error, then a clean frame
        cfg_bits_i      = 2'd3;
        cfg_parity_en_i = 1'b0;
        send_frame(8'h96, 8, 1'b0, 1'b0, 1'b0, -1, -1);
        wait_clks(32);
        check_eq("ferr_n",     n_ferr, 32'd1);
        check_eq("ferr_valid", {31'd0, rx_valid_o}, 32'd0);
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b1, -1, -1);
        check_eq("ferr_next_data",  {24'd0, rx_data_o}, 32'h3C);
        check_eq("ferr_next_valid", {31'd0, rx_valid_o}, 32'd1);
        accept_byte("ferr_accept");

        // Overrun: back-to-back frames, no accept
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, -1, -1);
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, -1, -1);
        wait_clks(2);
        check_eq("ovr_data",  {24'd0, rx_data_o}, 32'h11);
        check_eq("ovr_valid", {31'd0, rx_valid_o}, 32'd1);
        check_eq("ovr_n",     n_ovr, 32'd1);
        accept_byte("ovr_accept");

        // False start: 3-cycle low pulse
        rx_i = 1'b0;
        wait_clks(3);
        rx_i = 1'b1;
        wait_clks(40);
        check_eq("fstart_busy",  {31'd0, busy_o}, 32'd0);
        check_eq("fstart_valid", {31'd0, rx_valid_o}, 32'd0);
        check_eq("fstart_errs",  n_perr + n_ferr + n_ovr, 32'd3);

`ifdef UART_RX_MAJORITY_EN
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, -1, 1);
        check_eq("glitch_data",  {24'd0, rx_data_o}, 32'h55);
        check_eq("glitch_valid", {31'd0, rx_valid_o}, 32'd1);
        accept_byte("glitch_accept");
`endif

        // Reset mid-frame with a pending byte
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, -1, -1);
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, 5, -1);
        check_eq("rstmid_busy_before", {31'd0, busy_o}, 32'd1);
        rst_i = 1'b1;
        wait_clks(1);
        check_eq("rstmid_busy",  {31'd0, busy_o}, 32'd0);
        check_eq("rstmid_valid", {31'd0, rx_valid_o}, 32'd0);
        check_eq("rstmid_data",  {24'd0, rx_data_o}, 32'h00);
        rst_i = 1'b0;
        wait_clks(20);
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, -1, -1);
        check_eq("rstmid_next_data",  {24'd0, rx_data_o}, 32'h81);
        check_eq("rstmid_next_valid", {31'd0, rx_valid_o}, 32'd1);
        accept_byte("rstmid_accept");

        // Disable mid-frame with a pending byte
        send_frame(8'h42, 8, 1'b0, 1'b0, 1'b1, -1, -1);
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, 5, -1);
        check_eq("dis_busy_before", {31'd0, busy_o}, 32'd1);
        cfg_en_i = 1'b0;
        wait_clks(1);
        check_eq("dis_busy",  {31'd0, busy_o}, 32'd0);
        check_eq("dis_valid", {31'd0, rx_valid_o}, 32'd1);
        check_eq("dis_data",  {24'd0, rx_data_o}, 32'h42);
        cfg_en_i = 1'b1;
        wait_clks(20);
        accept_byte("dis_accept");
        send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1, -1, -1);
        check_eq("dis_next_data",  {24'd0, rx_data_o}, 32'h81);
        check_eq("dis_next_valid", {31'd0, rx_valid_o}, 32'd1);
        accept_byte("dis_next_accept");

        wait_clks(4);
        check_eq("final_perr", n_perr, 32'd1);
        check_eq("final_ferr", n_ferr, 32'd1);
        check_eq("final_ovr",  n_ovr,  32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver for the APB UART, the counterpart of the existing transmitter: same frame format, divider semantics and configuration fields. It synchronises the external `rx_i` line, detects start bits, samples 5–8 data bits LSB-first, checks optional even parity and the stop bit, then presents each byte on a valid/ready output toward the RX FIFO and register file.

## Interface
- No parameters; all configuration is run-time.
- `clk_i` input 1: system clock. One clock domain.
- `rst_i` input 1: reset, synchronous, active-high.
- `rx_i` input 1: serial line, asynchronous, idle high.
- `busy_o` output 1: high whenever the FSM is not in IDLE.
- `cfg_en_i` input 1: receiver enable.
- `cfg_div_i` input 16: bit period is `cfg_div_i`+1 cycles. Minimum value 4.
- `cfg_parity_en_i` input 1: one even-parity bit follows the data bits.
- `cfg_bits_i` input 2: data bits = `cfg_bits_i`+5.
- `rx_data_o` output 8: received byte, zero-extended above the configured width.
- `rx_valid_o` output 1: byte available.
- `rx_ready_i` input 1: consumer accepts the byte.
- `err_parity_o` output 1: one-cycle pulse on a parity mismatch.
- `err_frame_o` output 1: one-cycle pulse when the stop bit samples as 0.
- `err_overrun_o` output 1: one-cycle pulse when a completed frame is dropped.

## Operation
- **Input conditioning.** `rx_i` passes through a 2-flop synchroniser (s1, s2), then a 3rd flop (s3) for edge detection. All three reset to 1.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
- **IDLE → START:** when `cfg_en_i` is high and s3=1, s2=0 (falling edge). The baud counter clears to 0.
- **START:** sample at counter == `cfg_div_i`>>1.
  - Sample 1 (false start, glitch): return to IDLE.
  - Sample 0: go to DATA and clear the counter.
- **DATA:** sample at counter == `cfg_div_i`, then clear the counter.
  - Shift the sample into bit position `bit_cnt`; XOR it into the parity accumulator.
  - After `cfg_bits_i`+5 samples, go to PARITY if `cfg_parity_en_i`, else to STOP.
- **PARITY:** one sample, compared with the accumulator (even parity, matching the transmitter). A mismatch sets an internal flag.
- **STOP:** one sample, then always return to IDLE. Only the first stop bit is checked; a second stop bit is seen as idle line.
  - Stop sample 0: pulse `err_frame_o`, discard the byte.
  - Parity flag set: pulse `err_parity_o`, discard the byte.
  - Otherwise, if `rx_valid_o` is high: pulse `err_overrun_o`; the old byte is kept and the new one dropped.
  - Otherwise: load `rx_data_o` and set `rx_valid_o`.
  - Frame error takes priority over parity error, which takes priority over overrun. Only one error pulse per frame.
- **Handshake.** `rx_valid_o` stays high, with `rx_data_o` stable, until the cycle `rx_valid_o`&`rx_ready_i` is high; it clears on the next edge. If an accept and a new byte load happen in the same cycle, the new byte loads, `rx_valid_o` stays 1, and there is no overrun.
- **Disable.** `cfg_en_i` low forces IDLE and clears the bit and baud counters on the next edge. A pending output byte is retained.
- **Configuration changes.** `cfg_*` must be stable while `busy_o` is high; a change mid-frame gives undefined data but must not hang the FSM.
- **Arithmetic.** The 16-bit baud counter never wraps: it clears at its compare value. `bit_cnt` is 3 bits.

## Timing
- **Reset values:** `rx_data_o`=0x00; `rx_valid_o`, `busy_o` and all `err_*` = 0; FSM in IDLE.
- **Edge detect:** a low level on `rx_i` reaches s2 two edges later. START is entered on the edge after the s3=1, s2=0 cycle.
- **Frame length:** the stop bit is sampled about ½ bit into the stop bit. `rx_valid_o` or the error pulse rises on the edge immediately after the STOP sample cycle.
- **Resynchronisation:** back-to-back frames with one stop bit are received without loss, because IDLE is re-entered mid-stop-bit.
- **Reset mid-frame:** the next edge returns to IDLE. Outputs go to their reset values; no error pulse is produced.

## Configuration
- **`UART_RX_MAJORITY_EN` defined:** each START, DATA, PARITY and STOP sample is the 2-of-3 majority of s2 at compare−2, compare−1 and compare. This rejects single-cycle glitches.
- **`UART_RX_MAJORITY_EN` undefined:** single sample of s2 at the compare cycle; the majority logic is absent.

## Structure
- **Package `uart_pkg`:** the rx state enum and constants `UART_MIN_BITS`=5 and `UART_SYNC_STAGES`=2.
- **Sub-module `uart_rx_sampler`:** holds the synchroniser, the edge detector and the optional majority filter. Outputs: `line_o` (sampled level) and `fall_o` (falling-edge pulse).

## Test plan
- **Basic frame:** div=15, 8N1, send 0xA5 → `rx_data_o`=0xA5 and `rx_valid_o` held until `rx_ready_i`, then cleared next edge.
- **Parity:** 7 bits with parity, send 0x35 with correct parity → 0x35 delivered. Same frame with the parity bit flipped → `err_parity_o` pulse, no valid.
- **Frame error:** stop bit driven 0 → `err_frame_o` pulse, `rx_valid_o` stays 0, next frame 0x3C received correctly.
- **Overrun:** two frames 0x11 then 0x22 with `rx_ready_i`=0 → `rx_data_o`=0x11, one `err_overrun_o` pulse.
- **False start / glitch:** 3-cycle low pulse on `rx_i` → FSM returns to IDLE, no outputs. With `UART_RX_MAJORITY_EN`, a 1-cycle glitch mid-bit on a 0x55 frame → 0x55 still received.
- **Reset / disable mid-frame:** `rst_i` after 4 data bits → all outputs return to reset values; a subsequent 0x81 frame is received correctly. Same sequence using `cfg_en_i` low → FSM returns to IDLE, pending byte kept.
